// File: rtl/shift_pkg.sv
// Shared types for the shift issue stage: out_op encodings, the six shift
// funct codes, the entry payload carried through the skid buffer and a
// small funct decoder.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2
  } shift_op_e;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef struct packed {
    shift_op_e   op;
    logic [4:0]  shamt;
    logic [31:0] data;
    logic [4:0]  rd;
  } shift_entry_t;

  localparam int ENTRY_W = $bits(shift_entry_t);

  typedef struct packed {
    logic      legal;
    logic      var_amt;
    shift_op_e op;
  } funct_dec_t;

  // Variable forms take the amount from rs[4:0]; anything else is not a shift.
  function automatic funct_dec_t decode_funct(input logic [5:0] funct);
    funct_dec_t d;
    d = '{legal: 1'b1, var_amt: 1'b0, op: OP_SLL};
    case (funct)
      FUNCT_SLL:  d.op = OP_SLL;
      FUNCT_SRL:  d.op = OP_SRL;
      FUNCT_SRA:  d.op = OP_SRA;
      FUNCT_SLLV: begin d.op = OP_SLL; d.var_amt = 1'b1; end
      FUNCT_SRLV: begin d.op = OP_SRL; d.var_amt = 1'b1; end
      FUNCT_SRAV: begin d.op = OP_SRA; d.var_amt = 1'b1; end
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush.
// The main entry drives the output; the skid entry only fills when a push
// arrives while main is held. push_ready is a flop output (skid empty).
module shift_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push_fire;
  logic         main_free;

  assign push_ready = !skid_valid;
  assign push_fire  = push_valid && push_ready;
  // Main can take new content when empty or draining this cycle.
  assign main_free  = !main_valid || pop_ready;
  assign pop_valid  = main_valid;
  assign pop_data   = main_data;

  // Entry storage: skid refills main first, otherwise input goes straight to main.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else if (push_fire) begin
        main_valid <= 1'b1;
        main_data  <= push_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (push_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= push_data;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// ID/EX issue stage for the shift datapath: decodes the six shift functts,
// resolves the shift amount, and hands a normalised op to execute through a
// two-entry skid buffer. Non-shift functs are consumed and flagged on
// `illegal` one cycle later.
// Optional macro SHIFT_ISSUE_FWD_EN: writeback data bypasses the register-file
// read values for rs/rt at capture time.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_shamt,
  input  logic [4:0]       in_rs_addr,
  input  logic [4:0]       in_rt_addr,
  input  logic [4:0]       in_rd_addr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [4:0]       out_shamt,
  output logic [31:0]      out_data,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] shift_cnt
);

  funct_dec_t          dec;
  logic [4:0]          rs_amt;
  logic [31:0]         rt_eff;
  shift_entry_t        in_entry;
  shift_entry_t        out_entry;
  logic [ENTRY_W-1:0]  pop_bits;
  logic                in_fire;
  logic                out_fire;
  logic                illegal_q;
  logic [CNT_W-1:0]    cnt_q;

  assign dec = decode_funct(in_funct);

`ifdef SHIFT_ISSUE_FWD_EN
  logic fwd_rs;
  logic fwd_rt;
  logic unused_rs_hi;

  assign fwd_rs = wb_we && (wb_addr != 5'd0) && (wb_addr == in_rs_addr);
  assign fwd_rt = wb_we && (wb_addr != 5'd0) && (wb_addr == in_rt_addr);

  // Bypass writeback data over stale register-file reads.
  always_comb begin
    rs_amt = fwd_rs ? wb_data[4:0] : in_rs_val[4:0];
    rt_eff = fwd_rt ? wb_data : in_rt_val;
  end

  assign unused_rs_hi = ^in_rs_val[31:5];
`else
  logic unused_fwd;

  // Register-file values used as read.
  always_comb begin
    rs_amt = in_rs_val[4:0];
    rt_eff = in_rt_val;
  end

  assign unused_fwd = ^{wb_we, wb_addr, wb_data, in_rs_addr, in_rt_addr,
                        in_rs_val[31:5]};
`endif

  // Build the normalised payload; only rs[4:0] matters for variable shifts.
  always_comb begin
    in_entry       = '0;
    in_entry.op    = dec.op;
    in_entry.shamt = dec.var_amt ? rs_amt : in_shamt;
    in_entry.data  = rt_eff;
    in_entry.rd    = in_rd_addr;
  end

  // Illegal functs still complete the input handshake but are never enqueued.
  shift_skid_buf #(
    .W (ENTRY_W)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .push_valid (in_valid && dec.legal),
    .push_ready (in_ready),
    .push_data  (in_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_bits)
  );

  assign out_entry = pop_bits;
  assign out_op    = out_entry.op;
  assign out_shamt = out_entry.shamt;
  assign out_data  = out_entry.data;
  assign out_rd    = out_entry.rd;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // One-cycle pulse for a consumed non-shift funct; a flush squashes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= in_fire && !dec.legal && !flush;
  end

  assign illegal = illegal_q;

  // Saturating count of output transfers; a flush in the same cycle still counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       cnt_q <= '0;
    else if (out_fire && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign shift_cnt = cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with hand-computed expectations.
// Counter width is reduced so saturation is reachable in a short run.
module tb_shift_issue_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_funct;
  logic [4:0]    in_shamt;
  logic [4:0]    in_rs_addr;
  logic [4:0]    in_rt_addr;
  logic [4:0]    in_rd_addr;
  logic [31:0]   in_rs_val;
  logic [31:0]   in_rt_val;
  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_op;
  logic [4:0]    out_shamt;
  logic [31:0]   out_data;
  logic [4:0]    out_rd;
  logic          illegal;
  logic [CW-1:0] shift_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int ready_low;

  shift_issue_stage #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_shamt   (in_shamt),
    .in_rs_addr (in_rs_addr),
    .in_rt_addr (in_rt_addr),
    .in_rd_addr (in_rd_addr),
    .in_rs_val  (in_rs_val),
    .in_rt_val  (in_rt_val),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_shamt  (out_shamt),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .illegal    (illegal),
    .shift_cnt  (shift_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
    in_valid  = 1'b1;
    in_funct  = f;
    in_shamt  = sa;
    in_rs_val = rs;
    in_rt_val = rt;
    in_rd_addr = rd;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_funct = '0; in_shamt = '0;
    in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0; in_rs_val = '0; in_rt_val = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    repeat (2) tick();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_payload",   {out_op, out_shamt, out_rd, 20'd0}, 32'd0);
    chk("rst_data",      out_data, 32'd0);
    chk("rst_illegal",   32'(illegal), 32'd0);
    chk("rst_cnt",       32'(shift_cnt), 32'd0);
    reset_n = 1'b1;
    tick();

    // sra with immediate shamt
    out_ready = 1'b1;
    offer(6'b000011, 5'd4, 32'h0, 32'h8000_0000, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("sra_valid", 32'(out_valid), 32'd1);
    chk("sra_op",    32'(out_op),    32'd2);
    chk("sra_shamt", 32'(out_shamt), 32'd4);
    chk("sra_data",  out_data,       32'h8000_0000);
    chk("sra_rd",    32'(out_rd),    32'd9);
    tick();
    chk("sra_cnt",   32'(shift_cnt), 32'd1);
    chk("sra_drain", 32'(out_valid), 32'd0);

    // srav: only rs[4:0] used, instruction shamt ignored
    offer(6'b000111, 5'd31, 32'hFFFF_FFE3, 32'h0000_F000, 5'd10);
    tick();
    in_valid = 1'b0;
    chk("srav_shamt", 32'(out_shamt), 32'd3);
    chk("srav_op",    32'(out_op),    32'd2);
    tick();
    chk("srav_cnt",   32'(shift_cnt), 32'd2);

    // three back-to-back sll with out_ready low for two cycles
    offer(6'b000000, 5'd1, 32'h0, 32'h11, 5'd1);
    tick();
    chk("bb_a_rd", 32'(out_rd), 32'd1);
    out_ready = 1'b0;
    offer(6'b000000, 5'd2, 32'h0, 32'h22, 5'd2);
    tick();
    chk("bb_hold_rd",  32'(out_rd),   32'd1);
    chk("bb_ready_lo", 32'(in_ready), 32'd0);
    offer(6'b000000, 5'd3, 32'h0, 32'h33, 5'd3);
    tick();
    chk("bb_hold_data", out_data,      32'h11);
    chk("bb_ready_lo2", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bb_b_rd",      32'(out_rd),   32'd2);
    chk("bb_ready_up",  32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bb_c_rd",      32'(out_rd),    32'd3);
    chk("bb_c_shamt",   32'(out_shamt), 32'd3);
    chk("bb_skid_empty", 32'(in_ready), 32'd1);
    tick();
    chk("bb_done",      32'(out_valid), 32'd0);
    chk("bb_cnt",       32'(shift_cnt), 32'd5);

    // non-shift funct consumed, illegal pulses once
    offer(6'b100000, 5'd0, 32'h1, 32'h2, 5'd4);
    tick();
    in_valid = 1'b0;
    chk("ill_valid", 32'(out_valid), 32'd0);
    chk("ill_pulse", 32'(illegal),   32'd1);
    tick();
    chk("ill_clear", 32'(illegal),   32'd0);

    // fill main and skid, then flush with an input offered
    out_ready = 1'b0;
    offer(6'b000010, 5'd1, 32'h0, 32'h44, 5'd4);
    tick();
    offer(6'b000010, 5'd2, 32'h0, 32'h55, 5'd5);
    tick();
    chk("full_ready", 32'(in_ready), 32'd0);
    offer(6'b000010, 5'd3, 32'h0, 32'h66, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_nodeliver", 32'(out_valid), 32'd0);
    // flush while accept is possible: offered instruction dropped, no illegal
    offer(6'b100000, 5'd0, 32'h0, 32'h77, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_drop_valid", 32'(out_valid), 32'd0);
    chk("fl_no_illegal", 32'(illegal),   32'd0);
    // flush coincident with a transfer still counts it
    offer(6'b000000, 5'd0, 32'h0, 32'h88, 5'd8);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_xfer_cnt", 32'(shift_cnt), 32'd6);
    chk("fl_xfer_clr", 32'(out_valid), 32'd0);

    // writeback forwarding on rt
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    in_rt_addr = 5'd5;
    offer(6'b000010, 5'd1, 32'h0, 32'h0000_AAAA, 5'd11);
    tick();
    in_valid = 1'b0;
`ifdef SHIFT_ISSUE_FWD_EN
    chk("fwd_rt", out_data, 32'h0000_1234);
`else
    chk("fwd_rt", out_data, 32'h0000_AAAA);
`endif
    tick();
    // r0 never forwarded
    wb_addr = 5'd0; in_rt_addr = 5'd0;
    offer(6'b000010, 5'd1, 32'h0, 32'h0000_BBBB, 5'd12);
    tick();
    in_valid = 1'b0;
    chk("fwd_r0", out_data, 32'h0000_BBBB);
    tick();
    // forwarding on rs for a variable shift
    wb_addr = 5'd7; wb_data = 32'h0000_0009; in_rs_addr = 5'd7;
    offer(6'b000110, 5'd0, 32'h0000_0002, 32'h1, 5'd13);
    tick();
    in_valid = 1'b0;
`ifdef SHIFT_ISSUE_FWD_EN
    chk("fwd_rs", 32'(out_shamt), 32'd9);
`else
    chk("fwd_rs", 32'(out_shamt), 32'd2);
`endif
    chk("srlv_op", 32'(out_op), 32'd1);
    tick();
    wb_we = 1'b0; in_rs_addr = 5'd0;
    chk("fwd_cnt", 32'(shift_cnt), 32'd9);

    // full-rate stream: in_ready never drops, counter saturates at 15
    ready_low = 0;
    offer(6'b000000, 5'd1, 32'h0, 32'h1, 5'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!in_ready) ready_low++;
    end
    in_valid = 1'b0;
    tick();
    chk("stream_ready", 32'(ready_low), 32'd0);
    chk("cnt_sat",      32'(shift_cnt), 32'd15);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    offer(6'b000000, 5'd1, 32'h0, 32'h1, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_cnt",   32'(shift_cnt), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
